// File: rtl/stream_filter_pkg.sv
// Shared types for the stream filter family: packet FSM state encoding.
package stream_filter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } filter_state_e;

endpackage

// File: rtl/stream_packet_filter_oreg.sv
// One-entry output register that breaks the valid/data path toward the consumer.
module stream_packet_filter_oreg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  ready_o
);

  logic                  valid_d, valid_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  last_d, last_q;

  // A new beat may enter when the register is empty or drains this cycle.
  assign ready_o = ~valid_q | ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/stream_packet_filter.sv
// Packet-granular stream filter: forwards or consumes whole packets, decided on the first beat.
module stream_packet_filter
  import stream_filter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  drop_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  input  logic                  clear_i,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o,
  output logic                  dropping_o
);

  filter_state_e        state_d, state_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 load;
  logic                 cnt_inc;
  logic                 in_hs;
  logic                 oreg_ready;

  // Discarded beats never need output space, so they ignore back-pressure.
  assign ready_o = (state_q == DROP) || (state_q == IDLE && drop_i) ? 1'b1 : oreg_ready;
  assign in_hs   = valid_i & ready_o;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          if (drop_i) begin
            cnt_inc = 1'b1;
            if (!last_i) state_d = DROP;
          end else begin
            load = 1'b1;
            if (!last_i) state_d = PASS;
          end
        end
      end
      PASS: begin
        if (in_hs) begin
          load = 1'b1;
          if (last_i) state_d = IDLE;
        end
      end
      DROP: begin
        if (in_hs && last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  stream_packet_filter_oreg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_oreg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .data_i (data_i),
    .last_i (last_i),
    .ready_i(ready_i),
    .valid_o(valid_o),
    .data_o (data_o),
    .last_o (last_o),
    .ready_o(oreg_ready)
  );

  assign drop_cnt_o = cnt_q;
  assign dropping_o = (state_q == DROP);

endmodule

// File: tb/tb_stream_packet_filter.sv
// Scoreboard bench for stream_packet_filter: directed packets plus a randomized packet mix.
module tb_stream_packet_filter;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rstN;
  logic          validIn;
  logic          readyOut;
  logic [DW-1:0] dataIn;
  logic          lastIn;
  logic          dropIn;
  logic          validOut;
  logic          readyIn;
  logic [DW-1:0] dataOut;
  logic          lastOut;
  logic          clearIn;
  logic [CW-1:0] dropCnt;
  logic          dropping;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t   expQ[$];
  beat_t   popped;
  int      totalChecks = 0;
  int      passChecks  = 0;
  bit      pktActive   = 0;
  bit      pktDrop     = 0;
  int      expCnt      = 0;
  bit      heldValid   = 0;
  logic [DW-1:0] heldData;
  logic    heldLast;

  always #5 clk = ~clk;

  stream_packet_filter #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .valid_i   (validIn),
    .ready_o   (readyOut),
    .data_i    (dataIn),
    .last_i    (lastIn),
    .drop_i    (dropIn),
    .valid_o   (validOut),
    .ready_i   (readyIn),
    .data_o    (dataOut),
    .last_o    (lastOut),
    .clear_i   (clearIn),
    .drop_cnt_o(dropCnt),
    .dropping_o(dropping)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    totalChecks++;
    if (actual === expected) passChecks++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  // Monitor pops one expected beat per output handshake and watches stall stability.
  always @(negedge clk) begin
    if (!rstN) begin
      heldValid = 0;
    end else if (validOut && readyIn) begin
      if (expQ.size() == 0) begin
        totalChecks++;
        $display("[TB] FAIL unexpected_beat: actual data=0x%0h last=%0b required no beat", dataOut, lastOut);
      end else begin
        popped = expQ.pop_front();
        checkOutput("out_data", dataOut, popped.data);
        checkOutput("out_last", lastOut, popped.last);
      end
      heldValid = 0;
    end else if (validOut) begin
      if (heldValid) begin
        checkOutput("stall_data_stable", dataOut, heldData);
        checkOutput("stall_last_stable", lastOut, heldLast);
      end
      heldData  = dataOut;
      heldLast  = lastOut;
      heldValid = 1;
    end else begin
      heldValid = 0;
    end
  end

  // Reference model of one accepted beat; called on the accepting clock edge.
  task automatic modelAccept(input logic [DW-1:0] d, input logic l, input logic dr, output bit fwd);
    if (!pktActive) begin
      pktDrop = dr;
      if (clearIn) expCnt = 0;
      else if (dr && expCnt != 3) expCnt++;
    end else if (clearIn) begin
      expCnt = 0;
    end
    fwd = !pktDrop;
    if (fwd) expQ.push_back('{data: d, last: l});
    pktActive = !l;
  endtask

  // Presents one beat (entered and left just after a rising edge) until accepted.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic l, input logic dr,
                               input bit randReady, output int waits);
    bit acc;
    bit fwd;
    validIn = 1'b1;
    dataIn  = d;
    lastIn  = l;
    dropIn  = dr;
    waits   = 0;
    acc     = 0;
    fwd     = 0;
    while (!acc) begin
      @(negedge clk);
      acc = readyOut;
      @(posedge clk);
      if (!acc) begin
        waits++;
        if (waits > 64) begin
          totalChecks++;
          $display("[TB] FAIL accept_timeout: actual no handshake after %0d cycles required handshake", waits);
          break;
        end
        #1;
        if (randReady) readyIn = ($urandom_range(0, 3) != 0);
      end
    end
    if (acc) modelAccept(d, l, dr, fwd);
    #1;
    validIn = 1'b0;
    lastIn  = 1'b0;
    dropIn  = 1'b0;
    if (acc && fwd) checkOutput("fwd_latency_valid", validOut, 1);
    if (randReady) readyIn = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearCounter();
    clearIn = 1'b1;
    @(posedge clk);
    #1;
    clearIn = 1'b0;
    expCnt  = 0;
  endtask

  int w;
  logic [DW-1:0] rdata;
  int expTable[5] = '{1, 2, 3, 3, 3};

  initial begin
    rstN = 1'b0; validIn = 1'b0; dataIn = '0; lastIn = 1'b0; dropIn = 1'b0;
    readyIn = 1'b1; clearIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid_o", validOut, 0);
    checkOutput("reset_data_o", dataOut, 0);
    checkOutput("reset_last_o", lastOut, 0);
    checkOutput("reset_drop_cnt", dropCnt, 0);
    checkOutput("reset_dropping", dropping, 0);
    rstN = 1'b1;
    idleCycles(1);

    $display("[TB] single-beat packets");
    applyStimulus(32'hA, 1, 0, 0, w);
    applyStimulus(32'hB, 1, 1, 0, w);
    applyStimulus(32'hC, 1, 0, 0, w);
    idleCycles(3);
    checkOutput("single_drop_cnt", dropCnt, 1);

    $display("[TB] 4-beat dropped packet under back-pressure");
    clearCounter();
    readyIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("drop_dropping_o", dropping, (i > 0) ? 1 : 0);
      @(posedge clk);
      #1;
      applyStimulus(32'h100 + i, (i == 3), (i == 0), 0, w);
      checkOutput("drop_accept_wait", w, 0);
      checkOutput("drop_valid_o", validOut, 0);
    end
    checkOutput("drop4_cnt", dropCnt, 1);
    checkOutput("drop4_dropping_end", dropping, 0);
    readyIn = 1'b1;
    idleCycles(2);

    $display("[TB] 3-beat forwarded packet with stall");
    applyStimulus(32'h200, 0, 0, 0, w);
    readyIn = 1'b0;
    fork
      applyStimulus(32'h201, 0, 1, 0, w);
      begin
        repeat (2) @(posedge clk);
        #1;
        readyIn = 1'b1;
      end
    join
    applyStimulus(32'h202, 1, 0, 0, w);
    idleCycles(3);
    checkOutput("fwd3_drop_cnt", dropCnt, 1);

    $display("[TB] counter saturation and clear");
    clearCounter();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h300 + i, 1, 1, 0, w);
      checkOutput("sat_cnt", dropCnt, expTable[i]);
    end
    clearIn = 1'b1;
    applyStimulus(32'h305, 1, 1, 0, w);
    clearIn = 1'b0;
    checkOutput("clear_wins_cnt", dropCnt, 0);

    $display("[TB] reset mid-packet");
    applyStimulus(32'h400, 0, 1, 0, w);
    applyStimulus(32'h401, 0, 0, 0, w);
    checkOutput("mid_dropping_pre", dropping, 1);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    pktActive = 0;
    expCnt = 0;
    expQ.delete();
    checkOutput("mid_reset_cnt", dropCnt, 0);
    checkOutput("mid_reset_dropping", dropping, 0);
    checkOutput("mid_reset_valid", validOut, 0);
    applyStimulus(32'h55, 1, 0, 0, w);
    idleCycles(3);
    checkOutput("mid_reset_cnt_after", dropCnt, 0);

    $display("[TB] random packet mix");
    rdata = 32'h1000;
    for (int p = 0; p < 30; p++) begin
      int len;
      logic dr;
      len = $urandom_range(1, 4);
      dr  = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
          readyIn = ($urandom_range(0, 3) != 0);
        end
        applyStimulus(rdata, (b == len - 1), (b == 0) ? dr : logic'($urandom_range(0, 1)), 1, w);
        rdata = rdata + 1;
      end
    end
    readyIn = 1'b1;
    idleCycles(5);
    checkOutput("random_queue_drained", expQ.size(), 0);
    checkOutput("random_drop_cnt", dropCnt, expCnt);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/stream_packet_filter.md
# stream_packet_filter

Packet-granular successor to the single-beat stream filter: decides once per packet, on its first beat, whether the whole packet is forwarded or silently consumed, and holds that decision until the beat flagged `last_i`. Forwarded beats pass through a one-entry output register, breaking the valid/data timing path. A saturating counter reports how many packets were dropped. The block sits on valid/ready streams in front of consumers that must never see partial packets.

## Interface
- `DATA_WIDTH`, default 32: payload width in bits, ≥1.
- `CNT_WIDTH`, default 16: width of the dropped-packet counter, ≥1.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `valid_i`  in  1  upstream beat valid.
- `ready_o`  out  1  upstream beat accepted.
- `data_i`  in  DATA_WIDTH  upstream payload.
- `last_i`  in  1  final beat of the packet.
- `drop_i`  in  1  drop request; sampled only on a packet's first beat.
- `valid_o`  out  1  downstream beat valid (registered).
- `ready_i`  in  1  downstream accepts beat.
- `data_o`  out  DATA_WIDTH  downstream payload (registered).
- `last_o`  out  1  downstream last flag (registered).
- `clear_i`  in  1  synchronous clear of the drop counter.
- `drop_cnt_o`  out  CNT_WIDTH  dropped packets since reset/clear, saturating.
- `dropping_o`  out  1  high while in state DROP.

## Operation
- Input handshake: `valid_i & ready_o`. Output handshake: `valid_o & ready_i`.
- FSM states: IDLE (next beat is a first beat), PASS, DROP.
- IDLE, input handshake with `drop_i=1`: beat discarded; `drop_cnt_o` increments; next state DROP, or IDLE if `last_i=1`.
- IDLE, input handshake with `drop_i=0`: beat loaded into output register; next state PASS, or IDLE if `last_i=1`.
- PASS: every accepted beat is loaded; `last_i=1` returns to IDLE. `drop_i` is ignored.
- DROP: every accepted beat is discarded; `last_i=1` returns to IDLE. `drop_i` is ignored.
- `ready_o` = 1 in DROP, or in IDLE when `drop_i=1`.
- `ready_o` = `~valid_o | ready_i` otherwise.
- Output register: loads on a forwarded input handshake. Otherwise it clears `valid_o` on an output handshake. Otherwise it holds.
- While `valid_o=1 & ready_i=0`, `data_o` and `last_o` are stable.
- Counter: increments by 1 per dropped packet, counted at its first beat. It saturates at all-ones. If `clear_i` and an increment coincide, clear wins and the result is 0.
- `dropping_o` = (state == DROP).

## Timing
- Reset (`rst_ni=0` at a clock edge) forces: `valid_o=0`, `data_o=0`, `last_o=0`, `drop_cnt_o=0`, `dropping_o=0`, state IDLE.
- Reset mid-packet: the next beat after reset is treated as a first beat.
- Forward latency: 1 cycle from input handshake to `valid_o`.
- Throughput: 1 beat/cycle when `ready_i=1`.
- Dropped beats: accepted at 1 beat/cycle, independent of `ready_i`.
- Back-pressure: `ready_o` depends combinationally on `ready_i` (PASS/IDLE-forward) and on `drop_i` (IDLE only). No combinational path from `valid_i` to `ready_o`.
- Transition PASS→IDLE→DROP is possible back-to-back. A registered last beat may still be waiting downstream while the next packet's beats are dropped.
- `valid_i` deasserting mid-packet does not change state.

## Structure
- Shared package `stream_filter_pkg`: FSM state enum `filter_state_e` {IDLE, PASS, DROP}.
- One sub-module: `stream_packet_filter_oreg`.
  - Holds the one-entry output register.
  - Inputs: load, payload, last.
  - Outputs: valid/data/last, plus its ready term.
- FSM and counter stay in the top.

## Test plan
- Single-beat packets: `data_i` = 0xA,0xB,0xC, all `last_i=1`, `drop_i` = 0,1,0, `ready_i=1` → outputs 0xA, 0xC one cycle after acceptance; `drop_cnt_o=1`.
- 4-beat dropped packet with `drop_i=1` on beat 0 only, `ready_i=0` → all 4 beats accepted in 4 cycles; `valid_o` stays 0; `dropping_o` high for beats 1–3; counter=1.
- 3-beat forwarded packet with `drop_i` toggling on beats 1–2 and `ready_i` stalled 2 cycles on beat 1 → all 3 beats out in order; `data_o` stable during the stall; `last_o` only on beat 2.
- `CNT_WIDTH=2`, 5 dropped packets → counter 1,2,3,3,3. `clear_i` in the same cycle as the 6th drop → counter 0.
- `rst_ni=0` for 1 cycle after beat 1 of a 3-beat dropped packet, then send 0x55 with `drop_i=0`, `last_i=1` → 0x55 forwarded; counter 0 after reset.
- Random valid/ready/drop with a scoreboard → output equals the concatenation of non-dropped packets; no partial packets at the output.
